// File: rtl/register_file_sb.sv
// register_file_sb
// 32 x 32-bit register file with a per-register pending-write scoreboard.
//
// Ports:
//   Clk, Rst                    clock (rising edge) and asynchronous active-high reset
//   ReadRegister1/2             source register indices
//   WriteRegister, WriteData,
//   RegWrite                    write-back port; also retires one pending write
//   IssueValid, IssueDest       decode issue; adds one pending write to IssueDest
//   ReadData1/2                 combinational read data with write-back bypass
//   Hazard1/2, Stall            source operand still waiting on an outstanding write
//   ErrFlag                     sticky scoreboard overflow/underflow error
module register_file_sb (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    input  logic [4:0]  WriteRegister,
    input  logic [31:0] WriteData,
    input  logic        RegWrite,
    input  logic        IssueValid,
    input  logic [4:0]  IssueDest,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic        Hazard1,
    output logic        Hazard2,
    output logic        Stall,
    output logic        ErrFlag
);

    logic [31:0]      regFile [32];
    // Entry 0 is never incremented, so r0 can never appear pending.
    logic [31:0][1:0] pendingQ;
    logic [31:0][1:0] pendingD;
    logic             errFlagQ;
    logic             errFlagD;

    logic incHit;
    logic decHit;
    logic writeHit;

    assign incHit   = IssueValid && (IssueDest != 5'd0);
    assign decHit   = RegWrite && (WriteRegister != 5'd0);
    assign writeHit = decHit;

    // Read value with r0 forced to zero and a same-cycle write-back bypass.
    function automatic logic [31:0] readPort(
        input logic        rst,
        input logic [4:0]  idx,
        input logic        wrEn,
        input logic [4:0]  wrIdx,
        input logic [31:0] wrData,
        input logic [31:0] stored
    );
        logic [31:0] val;
        val = 32'd0;
        if (!rst && (idx != 5'd0)) begin
            if (wrEn && (wrIdx == idx)) begin
                val = wrData;
            end else begin
                val = stored;
            end
        end
        return val;
    endfunction

    // Pending operand, except when the last outstanding write is landing now.
    function automatic logic hazardFor(
        input logic       rst,
        input logic [4:0] idx,
        input logic [1:0] count,
        input logic       wrEn,
        input logic [4:0] wrIdx
    );
        logic hz;
        hz = 1'b0;
        if (!rst && (idx != 5'd0) && (count != 2'd0)) begin
            hz = 1'b1;
            if ((count == 2'd1) && wrEn && (wrIdx == idx)) begin
                hz = 1'b0;
            end
        end
        return hz;
    endfunction

    always_comb begin
        ReadData1 = readPort(Rst, ReadRegister1, RegWrite, WriteRegister, WriteData,
                             regFile[ReadRegister1]);
        ReadData2 = readPort(Rst, ReadRegister2, RegWrite, WriteRegister, WriteData,
                             regFile[ReadRegister2]);
        Hazard1   = hazardFor(Rst, ReadRegister1, pendingQ[ReadRegister1], RegWrite,
                              WriteRegister);
        Hazard2   = hazardFor(Rst, ReadRegister2, pendingQ[ReadRegister2], RegWrite,
                              WriteRegister);
        Stall     = Hazard1 | Hazard2;
        ErrFlag   = errFlagQ;
    end

    // Scoreboard next state: saturating counters, errors are sticky.
    always_comb begin
        pendingD = pendingQ;
        errFlagD = errFlagQ;
        // Issue and retire on the same index cancel out.
        if (!(incHit && decHit && (IssueDest == WriteRegister))) begin
            if (incHit) begin
                if (pendingQ[IssueDest] == 2'd3) begin
                    errFlagD = 1'b1;
                end else begin
                    pendingD[IssueDest] = pendingQ[IssueDest] + 2'd1;
                end
            end
            if (decHit) begin
                if (pendingQ[WriteRegister] == 2'd0) begin
                    errFlagD = 1'b1;
                end else begin
                    pendingD[WriteRegister] = pendingQ[WriteRegister] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pendingQ <= '0;
            errFlagQ <= 1'b0;
        end else begin
            pendingQ <= pendingD;
            errFlagQ <= errFlagD;
        end
    end

    // Data write still happens on a scoreboard underflow.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < 32; i++) begin
                regFile[i] <= 32'd0;
            end
        end else if (writeHit) begin
            regFile[WriteRegister] <= WriteData;
        end
    end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 ReadRegister1  input  5  source register index, port 1.
REQ-005 ReadRegister2  input  5  source register index, port 2.
REQ-006 WriteRegister  input  5  destination index from the write-back stage.
REQ-007 WriteData  input  32  result from the write-back stage.
REQ-008 RegWrite  input  1  write-back write enable.
REQ-009 IssueValid  input  1  decode issues an instruction that will write IssueDest.
REQ-010 IssueDest  input  5  destination index of the issued instruction.
REQ-011 ReadData1  output  32  port-1 read data (combinational).
REQ-012 ReadData2  output  32  port-2 read data (combinational).
REQ-013 Hazard1 / Hazard2  output  1 each  source operand still pending a write.
REQ-014 Stall  output  1  Hazard1 OR Hazard2.
REQ-015 ErrFlag  output  1  sticky scoreboard overflow/underflow error.

Function
REQ-016 Storage SHALL be 32 x 32-bit registers; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-017 On a rising Clk edge with RegWrite=1 and WriteRegister!=0, the block SHALL store WriteData into WriteRegister.
REQ-018 Reads SHALL be combinational: ReadDataN = 0 if ReadRegisterN=0; else WriteData if RegWrite=1 and WriteRegister=ReadRegisterN (same-cycle bypass); else the stored value.
REQ-019 Each register 1..31 SHALL have a 2-bit pending counter; register 0 SHALL have none and SHALL never be pending.
REQ-020 On each rising edge, the counter for IssueDest SHALL increment when IssueValid=1 and IssueDest!=0.
REQ-021 On each rising edge, the counter for WriteRegister SHALL decrement when RegWrite=1 and WriteRegister!=0.
REQ-022 Same-edge increment and decrement on the same index SHALL leave that counter unchanged; on different indices both SHALL apply.
REQ-023 An increment at count 3 SHALL leave the counter at 3 and set ErrFlag.
REQ-024 A decrement at count 0 SHALL leave the counter at 0, still perform the data write, and set ErrFlag.
REQ-025 ErrFlag SHALL remain set until reset.
REQ-026 HazardN SHALL be 1 when ReadRegisterN!=0 and pending count > 0.
REQ-027 HazardN SHALL be 0 when the pending count is 1 and RegWrite=1 with WriteRegister=ReadRegisterN in that cycle, because the value is bypassed.
REQ-028 Hazard and Stall SHALL be combinational from the current counters and inputs, with zero-cycle latency.
REQ-029 IssueValid SHALL be honoured independently of Stall; gating issue during a stall is the decode stage's responsibility.

Reset
REQ-030 Asserting Rst SHALL immediately clear all 32 registers, all pending counters and ErrFlag, regardless of Clk.
REQ-031 While Rst=1, writes and issues SHALL be ignored; ReadData1/2, Hazard1/2 and Stall SHALL be 0 (except bypass of WriteData, which SHALL also be suppressed).
REQ-032 Rst asserted mid-operation SHALL discard all pending state; the first edge after deassertion SHALL behave as after power-up.

Verification
REQ-033 Reset, then write 0xDEADBEEF to r5; next cycle read r5 on both ports -> ReadData1 = ReadData2 = 0xDEADBEEF.
REQ-034 Write 0x12345678 to r0, then read r0 -> 0; a same-cycle write to r0 with ReadRegister1=0 -> ReadData1 = 0.
REQ-035 Read r7 (stored 0x1) in the same cycle RegWrite writes 0xAA to r7 -> ReadData1 = 0xAA combinationally; stored value 0xAA after the edge.
REQ-036 Issue dest r3, then read r3 -> Hazard1 = 1 and Stall = 1; in the write-back cycle for r3 -> Hazard1 = 0 with bypassed data; next cycle counter = 0.
REQ-037 Issue r4 four times without writes -> counter = 3 and ErrFlag = 1; then a write to r9 with count 0 -> ErrFlag stays 1 and r9 is updated.
REQ-038 With r2 pending and holding 0x55, pulse Rst between edges -> r2 reads 0, Hazard = 0, ErrFlag = 0 immediately.
